audio_pwm_out: RTL

Consumer end of the filter's 8-bit unsigned sample stream (sample + one-cycle valid strobe). Converts each sample into a 256-clock PWM period on a single output pin, using a double-buffered duty register. Includes an anti-pop soft ramp between silence and mid-scale (0x80) on enable and disable. Sits between the filter output and the chip's audio pad.

---
 rtl/audio_pkg.sv | 30 +++
 rtl/pwm_counter_cmp.sv | 41 ++++
 rtl/audio_pwm_out.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the PWM audio output path.
// Holds the output FSM state type and the ramp helper.
package audio_pkg;

  localparam int PWM_BITS = 8;

  localparam logic [PWM_BITS-1:0] MIDSCALE = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RUN,
    RAMP_DOWN
  } state_t;

  // One ramp step toward mid-scale, from either side.
  function automatic logic [PWM_BITS-1:0] step_toward_mid(
    input logic [PWM_BITS-1:0] lvl
  );
    logic [PWM_BITS-1:0] r;
    r = lvl;
    if (lvl < MIDSCALE) begin
      r = lvl + 8'd1;
    end else if (lvl > MIDSCALE) begin
      r = lvl - 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_counter_cmp.sv
// pwm_counter_cmp: 256-clock period counter and registered comparator.
// Counter is parked at zero whenever run_en is low.
module pwm_counter_cmp
  import audio_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                run_en,
  input  logic [PWM_BITS-1:0] duty,
  output logic                cnt_wrap,
  output logic                pwm_out,
  output logic                period_start
);

  logic [PWM_BITS-1:0] cnt;

  assign cnt_wrap = run_en && (cnt == '1);

  // Free-running period counter, held at zero while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (run_en) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= '0;
    end
  end

  // Registered compare and start-of-period pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= (cnt < duty);
      period_start <= cnt_wrap;
    end
  end

endmodule

// File: rtl/audio_pwm_out.sv
// audio_pwm_out: sample stream to PWM pin with double-buffered duty.
// Soft ramps between silence and mid-scale avoid pops on enable/disable.
module audio_pwm_out
  import audio_pkg::*;
#(
  parameter int RAMP_DIV = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] sample_in,
  input  logic                sample_valid,
  output logic                pwm_out,
  output logic                period_start,
  output logic                underrun,
  output logic                overrun,
  output logic                running
);

  localparam logic [7:0] DIV_LAST = 8'(RAMP_DIV - 1);

  state_t              state, state_n;
  logic [PWM_BITS-1:0] level, level_n;
  logic [PWM_BITS-1:0] duty, duty_n;
  logic [7:0]          div, div_n;
  logic [PWM_BITS-1:0] shadow, shadow_n;
  logic                shadow_full, full_n;
  logic                underrun_n, overrun_n;

  logic                wrap;
  logic                step_due;
  logic [PWM_BITS-1:0] lvl_mid;
  logic [PWM_BITS-1:0] lvl_dec;

  assign step_due = (div == DIV_LAST);
  assign lvl_mid  = step_toward_mid(level);
  assign lvl_dec  = level - 8'd1;
  assign running  = (state == RUN);

  pwm_counter_cmp u_cnt (
    .clk          (clk),
    .rst          (rst),
    .run_en       (state != IDLE),
    .duty         (duty),
    .cnt_wrap     (wrap),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  // State, ramp and shadow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      level       <= '0;
      duty        <= '0;
      div         <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      level       <= level_n;
      duty        <= duty_n;
      div         <= div_n;
      shadow      <= shadow_n;
      shadow_full <= full_n;
      underrun    <= underrun_n;
      overrun     <= overrun_n;
    end
  end

  // Next-state: ramps step only on period boundaries; enable wins.
  always_comb begin
    state_n    = state;
    level_n    = level;
    duty_n     = duty;
    div_n      = div;
    shadow_n   = shadow;
    full_n     = shadow_full;
    underrun_n = 1'b0;
    overrun_n  = 1'b0;

    unique case (state)
      IDLE: begin
        level_n = '0;
        duty_n  = '0;
        div_n   = '0;
        full_n  = 1'b0;
        if (enable) begin
          state_n = RAMP_UP;
        end
      end

      RAMP_UP: begin
        full_n = 1'b0;
        if (!enable) begin
          state_n = RAMP_DOWN;
          div_n   = '0;
        end else if (wrap) begin
          if (level == MIDSCALE) begin
            state_n = RUN;
            div_n   = '0;
          end else if (step_due) begin
            div_n   = '0;
            level_n = lvl_mid;
            duty_n  = lvl_mid;
            if (lvl_mid == MIDSCALE) begin
              state_n = RUN;
            end
          end else begin
            div_n = div + 8'd1;
          end
        end
      end

      RUN: begin
        if (!enable) begin
          state_n = RAMP_DOWN;
          level_n = duty;
          div_n   = '0;
          full_n  = 1'b0;
        end else begin
          if (wrap) begin
            if (shadow_full) begin
              duty_n = shadow;
              full_n = 1'b0;
            end else begin
              underrun_n = 1'b1;
            end
          end
          if (sample_valid) begin
            shadow_n  = sample_in;
            full_n    = 1'b1;
            overrun_n = shadow_full && !wrap;
          end
        end
      end

      RAMP_DOWN: begin
        full_n = 1'b0;
        if (enable) begin
          state_n = RAMP_UP;
          div_n   = '0;
        end else if (wrap) begin
          if (level == '0) begin
            state_n = IDLE;
            div_n   = '0;
          end else if (step_due) begin
            div_n   = '0;
            level_n = lvl_dec;
            duty_n  = lvl_dec;
            if (lvl_dec == '0) begin
              state_n = IDLE;
            end
          end else begin
            div_n = div + 8'd1;
          end
        end
      end
    endcase
  end

endmodule
